appr_mac_array: RTL
===================

APPR_MAC_ARRAY -- requirements
Module: appr_mac_array

Interface
REQ-001 SHALL have parameters: N_LANES, default 4, number of parallel MAC lanes.
REQ-002 SHALL have parameter MAC_IN_WIDTH, default 9, signed operand width per lane.
REQ-003 SHALL have parameter N_BIT_APPR, default 8, number of approximable product LSBs; N_BIT_APPR <= 2*MAC_IN_WIDTH.
REQ-004 SHALL have parameter ACC_WIDTH, default 24, signed accumulator width; ACC_WIDTH >= 2*MAC_IN_WIDTH.
REQ-005 SHALL have parameter LEN_WIDTH, default 8, width of the frame-length field.
REQ-006 SHALL have ports, in order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid and in_ready are both high.
- a  in  N_LANES*MAC_IN_WIDTH  signed operands; lane k at [k*MAC_IN_WIDTH +: MAC_IN_WIDTH].
- b  in  N_LANES*MAC_IN_WIDTH  signed operands, same packing.
- appr_mask  in  N_BIT_APPR  approximation mask; sampled on first beat of frame.
- acc_len  in  LEN_WIDTH  beats per frame; sampled on first beat; 0 treated as 1.
- out_valid  out  1  frame result valid.
- out_ready  in  1  result consumed when out_valid and out_ready are both high.
- res  out  N_LANES*ACC_WIDTH  per-lane accumulated results, same packing.
- overflow  out  N_LANES  per-lane sticky saturation flag for current frame.

Function
REQ-007 SHALL implement FSM states IDLE, ACCUM, DRAIN, OUTPUT.
REQ-008 IDLE: in_ready=1; on accepted beat, latch appr_mask and acc_len, set beat count to 1, go to ACCUM, or to DRAIN if latched length <= 1.
REQ-009 ACCUM: in_ready=1; each accepted beat increments count; the beat making count equal to length moves FSM to DRAIN; gaps in in_valid are allowed.
REQ-010 DRAIN: in_ready=0 for exactly 2 cycles while the pipeline empties, then go to OUTPUT.
REQ-011 OUTPUT: in_ready=0, out_valid=1; res and overflow held stable until out_ready; on handshake, clear accumulators and overflow and go to IDLE.
REQ-012 Pipeline stage 1 SHALL register per-lane full-precision signed product P = a_k*b_k, 2*MAC_IN_WIDTH bits.
REQ-013 Approximation: for i < N_BIT_APPR, bit i of P SHALL be forced to 0 when latched appr_mask[i]=0; all-ones mask gives exact product.
REQ-014 Stage 2 SHALL sign-extend the masked product to ACC_WIDTH and add it to the lane accumulator.
REQ-015 Accumulation SHALL saturate to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; on any saturating add, set that lane's overflow bit until frame cleared.
REQ-016 Latency: with back-to-back beats, out_valid SHALL rise 3 rising edges after the edge accepting the last beat.
REQ-017 Lanes SHALL be fully independent; no cross-lane carry or saturation.
REQ-018 A new frame SHALL NOT be accepted until the previous result has been handshaken.

Reset
REQ-019 On rst high at a rising edge: FSM=IDLE, accumulators=0, pipeline valid bits=0, out_valid=0, res=0, overflow=0, in_ready=1 from the next cycle.
REQ-020 rst mid-frame (any state) SHALL discard the frame and in-flight products; no partial result SHALL ever appear on out_valid.
REQ-021 rst SHALL take priority over a simultaneous input or output handshake.

Verification
REQ-022 Exact frame: appr_mask=8'hFF, acc_len=4, lane0 a=3 b=-2 for 4 beats -> res lane0=-24, overflow=0, out_valid 3 edges after last beat.
REQ-023 Approximation: appr_mask=8'hFC, acc_len=1, lane0 a=3 b=5 -> 12; lane1 a=-1 b=1, mask 8'hFE -> -2.
REQ-024 Saturation: acc_len=128, all lanes a=-256 b=-256, exact -> each lane res=8388607, overflow=4'hF.
REQ-025 Backpressure: hold out_ready=0 for 5 cycles in OUTPUT -> res stable, in_ready=0, incoming in_valid ignored; result released on first out_ready=1.
REQ-026 Reset mid-frame: rst after 2 of 4 beats, then new frame acc_len=1 a=2 b=2 -> res lane0=4, no stale contribution.
REQ-027 Corner cases: acc_len=0 behaves as 1; in_valid gaps in ACCUM give the same result as back-to-back beats.

Source files
------------

// File: rtl/appr_mac_array.sv
// N-lane signed multiply-accumulate array with a per-frame mask that zeroes
// selected product LSBs. Uses a two-stage pipeline and saturating accumulators.
module appr_mac_array #(
  parameter int N_LANES      = 4,
  parameter int MAC_IN_WIDTH = 9,
  parameter int N_BIT_APPR   = 8,
  parameter int ACC_WIDTH    = 24,
  parameter int LEN_WIDTH    = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N_LANES*MAC_IN_WIDTH-1:0] a,
  input  logic [N_LANES*MAC_IN_WIDTH-1:0] b,
  input  logic [N_BIT_APPR-1:0]          appr_mask,
  input  logic [LEN_WIDTH-1:0]           acc_len,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [N_LANES*ACC_WIDTH-1:0]   res,
  output logic [N_LANES-1:0]             overflow
);

  localparam int PW = 2 * MAC_IN_WIDTH;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCUM  = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] OUTPUT = 2'd3;

  logic [1:0]            state;
  logic [N_BIT_APPR-1:0] mask_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  cnt;
  logic [LEN_WIDTH-1:0]  cnt_next;
  logic [LEN_WIDTH-1:0]  eff_len;
  logic                  drain_cnt;
  logic                  p_valid;
  logic                  accept;
  logic                  frame_done;
  logic [PW-1:0]         mask_ext;

  assign in_ready   = (state == IDLE) || (state == ACCUM);
  assign accept     = in_valid && in_ready;
  assign frame_done = (state == OUTPUT) && out_valid && out_ready;
  assign eff_len    = (acc_len == '0) ? LEN_WIDTH'(1) : acc_len;
  assign cnt_next   = cnt + LEN_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mask_q    <= '0;
      len_q     <= LEN_WIDTH'(1);
      cnt       <= '0;
      drain_cnt <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mask_q    <= appr_mask;
            len_q     <= eff_len;
            cnt       <= LEN_WIDTH'(1);
            drain_cnt <= 1'b0;
            state     <= (eff_len == LEN_WIDTH'(1)) ? DRAIN : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            cnt       <= cnt_next;
            drain_cnt <= 1'b0;
            if (cnt_next == len_q) state <= DRAIN;
          end
        end
        // Two cycles let the last product clear both pipeline stages.
        DRAIN: begin
          if (drain_cnt) begin
            drain_cnt <= 1'b0;
            state     <= OUTPUT;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        OUTPUT: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) p_valid <= 1'b0;
    else     p_valid <= accept;
  end

  always_comb begin
    mask_ext = '1;
    mask_ext[N_BIT_APPR-1:0] = mask_q;
  end

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    logic [PW-1:0]                prod;
    logic [PW-1:0]                a_ext;
    logic [PW-1:0]                b_ext;
    logic [PW-1:0]                masked;
    logic signed [ACC_WIDTH:0]    addend;
    logic signed [ACC_WIDTH:0]    sum;
    logic signed [ACC_WIDTH-1:0]  acc_r;
    logic                         ovf_r;
    logic                         sat;

    // The low PW bits of the product of the sign-extended operands equal the signed product.
    assign a_ext = {{MAC_IN_WIDTH{a[k*MAC_IN_WIDTH+MAC_IN_WIDTH-1]}}, a[k*MAC_IN_WIDTH +: MAC_IN_WIDTH]};
    assign b_ext = {{MAC_IN_WIDTH{b[k*MAC_IN_WIDTH+MAC_IN_WIDTH-1]}}, b[k*MAC_IN_WIDTH +: MAC_IN_WIDTH]};

    always_ff @(posedge clk) begin
      if (rst)         prod <= '0;
      else if (accept) prod <= a_ext * b_ext;
    end

    always_comb begin
      masked = prod & mask_ext;
      addend = (ACC_WIDTH+1)'($signed(masked));
      sum    = (ACC_WIDTH+1)'(acc_r) + addend;
      sat    = sum[ACC_WIDTH] != sum[ACC_WIDTH-1];
    end

    // Keep one guard bit and clamp toward the sign of the true sum.
    always_ff @(posedge clk) begin
      if (rst || frame_done) begin
        acc_r <= '0;
        ovf_r <= 1'b0;
      end else if (p_valid) begin
        if (sat) begin
          acc_r <= sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                  : {1'b0, {(ACC_WIDTH-1){1'b1}}};
          ovf_r <= 1'b1;
        end else begin
          acc_r <= sum[ACC_WIDTH-1:0];
        end
      end
    end

    assign res[k*ACC_WIDTH +: ACC_WIDTH] = acc_r;
    assign overflow[k] = ovf_r;
  end

endmodule
